// File: rtl/bus_host_arbiter_pkg.sv
// Shared types and constants for the bus host arbiter.
// The optional response timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
package bus_host_arbiter_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } arb_state_e;

    localparam int HOST_CORE              = 0;
    localparam int HOST_DBG               = 1;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // A single host still needs a one-bit index so vectors never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_host_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after the last grant, wrapping.
module rr_arbiter #(
    parameter int NrHosts = 2,
    parameter int IdxW    = 1
) (
    input  logic [NrHosts-1:0] i_req,
    input  logic [IdxW-1:0]    i_last_grant,
    output logic [NrHosts-1:0] o_gnt,
    output logic [IdxW-1:0]    o_idx,
    output logic               o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= NrHosts; k++) begin
            if (!o_valid && i_req[(int'(i_last_grant) + k) % NrHosts]) begin
                o_valid = 1'b1;
                o_idx   = IdxW'((int'(i_last_grant) + k) % NrHosts);
            end
        end
        if (o_valid) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one downstream bus port between NrHosts hosts.
// Define BUS_ARB_TIMEOUT_EN to terminate unanswered transactions with an error.
module bus_host_arbiter
    import bus_host_arbiter_pkg::*;
#(
    parameter int NrHosts       = 2,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NrHosts-1:0]              host_req_i,
    output logic [NrHosts-1:0]              host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
    input  logic [NrHosts-1:0]              host_we_i,
    input  logic [NrHosts*4-1:0]            host_be_i,
    input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
    output logic [NrHosts-1:0]              host_rvalid_o,
    output logic [DataWidth-1:0]            host_rdata_o,
    output logic [NrHosts-1:0]              host_err_o,
    output logic                            bus_req_o,
    output logic [AddressWidth-1:0]         bus_addr_o,
    output logic                            bus_we_o,
    output logic [3:0]                      bus_be_o,
    output logic [DataWidth-1:0]            bus_wdata_o,
    input  logic                            bus_rvalid_i,
    input  logic [DataWidth-1:0]            bus_rdata_i,
    input  logic                            bus_err_i,
    output logic                            busy_o
);

    localparam int IdxW = idx_width(NrHosts);

    arb_state_e          r_state;
    logic [IdxW-1:0]     r_last_grant;
    logic [IdxW-1:0]     r_owner;
    logic [NrHosts-1:0]  w_pick_gnt;
    logic [IdxW-1:0]     w_pick_idx;
    logic                w_pick_valid;
    logic                w_resp;
    logic                w_timeout;

    rr_arbiter #(
        .NrHosts (NrHosts),
        .IdxW    (IdxW)
    ) u_rr_arbiter (
        .i_req        (host_req_i),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_pick_gnt),
        .o_idx        (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

    assign w_resp = (r_state == WAIT_RESP) && bus_rvalid_i;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles) + 1;

    logic [CntW-1:0] r_wait_cnt;

    assign w_timeout = (r_state == WAIT_RESP) && !bus_rvalid_i &&
                       (r_wait_cnt == CntW'(TimeoutCycles - 1));

    // Counts unanswered WAIT_RESP cycles; anything else returns it to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if ((r_state == WAIT_RESP) && !w_resp && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_last_grant <= IdxW'(NrHosts - 1);
            r_owner      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_owner      <= w_pick_idx;
                        r_last_grant <= w_pick_idx;
                        r_state      <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (w_resp || w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an asserted reset silences a held request at once.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        bus_req_o     = 1'b0;
        bus_addr_o    = '0;
        bus_we_o      = 1'b0;
        bus_be_o      = '0;
        bus_wdata_o   = '0;
        if (rst_ni) begin
            if ((r_state == IDLE) && w_pick_valid) begin
                host_gnt_o  = w_pick_gnt;
                bus_req_o   = 1'b1;
                bus_addr_o  = host_addr_i[w_pick_idx*AddressWidth +: AddressWidth];
                bus_we_o    = host_we_i[w_pick_idx];
                bus_be_o    = host_be_i[w_pick_idx*4 +: 4];
                bus_wdata_o = host_wdata_i[w_pick_idx*DataWidth +: DataWidth];
            end
            if (w_resp) begin
                host_rvalid_o[r_owner] = 1'b1;
                host_err_o[r_owner]    = bus_err_i;
                host_rdata_o           = bus_rdata_i;
            end else if (w_timeout) begin
                host_rvalid_o[r_owner] = 1'b1;
                host_err_o[r_owner]    = 1'b1;
            end
        end
    end

    assign busy_o = (r_state == WAIT_RESP);

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model (BUS_ARB_TIMEOUT_EN aware).
module tb_bus_host_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N-1:0]      host_req_i;
    logic [N-1:0]      host_gnt_o;
    logic [N*AW-1:0]   host_addr_i;
    logic [N-1:0]      host_we_i;
    logic [N*4-1:0]    host_be_i;
    logic [N*DW-1:0]   host_wdata_i;
    logic [N-1:0]      host_rvalid_o;
    logic [DW-1:0]     host_rdata_o;
    logic [N-1:0]      host_err_o;
    logic              bus_req_o;
    logic [AW-1:0]     bus_addr_o;
    logic              bus_we_o;
    logic [3:0]        bus_be_o;
    logic [DW-1:0]     bus_wdata_o;
    logic              bus_rvalid_i;
    logic [DW-1:0]     bus_rdata_i;
    logic              bus_err_i;
    logic              busy_o;

    int chkCount = 0;
    int errCount = 0;

    bus_host_arbiter #(
        .NrHosts       (N),
        .DataWidth     (DW),
        .AddressWidth  (AW),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_addr_i   (host_addr_i),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_wdata_i  (host_wdata_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .bus_req_o     (bus_req_o),
        .bus_addr_o    (bus_addr_o),
        .bus_we_o      (bus_we_o),
        .bus_be_o      (bus_be_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i),
        .bus_err_i     (bus_err_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        chkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int h, input logic req, input logic [AW-1:0] addr,
                                 input logic we, input logic [3:0] be, input logic [DW-1:0] wdata);
        host_req_i[h]             = req;
        host_addr_i[h*AW +: AW]   = addr;
        host_we_i[h]              = we;
        host_be_i[h*4 +: 4]       = be;
        host_wdata_i[h*DW +: DW]  = wdata;
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        stepCycle();
        rst_ni       = 1'b0;
        host_req_i   = '0;
        host_addr_i  = '0;
        host_we_i    = '0;
        host_be_i    = '0;
        host_wdata_i = '0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        bus_err_i    = 1'b0;
        stepCycle();
        stepCycle();
        rst_ni = 1'b1;
    endtask

    // Transaction-level model: one outstanding transfer, round-robin after the last winner.
    bit mOutstanding = 1'b0;
    int mOwner = 0;
    int mLast  = N - 1;
    int mWait  = 0;

    initial begin
        forever begin
            logic [N-1:0]  expGnt, expRvalid, expErr;
            logic [DW-1:0] expRdata, expWdata;
            logic [AW-1:0] expAddr;
            logic [3:0]    expBe;
            logic          expReq, expWe, expBusy;
            int            pick;
            bit            done;
            @(negedge clk_i);
            expGnt = '0; expRvalid = '0; expErr = '0; expRdata = '0; expWdata = '0;
            expAddr = '0; expBe = '0; expReq = 1'b0; expWe = 1'b0; expBusy = 1'b0;
            pick = -1;
            done = 1'b0;
            if (!rst_ni) begin
                mOutstanding = 1'b0;
                mOwner = 0;
                mLast  = N - 1;
                mWait  = 0;
            end else begin
                expBusy = mOutstanding;
                if (!mOutstanding) begin
                    for (int k = 1; k <= N; k++) begin
                        if (pick < 0 && host_req_i[(mLast + k) % N]) pick = (mLast + k) % N;
                    end
                    if (pick >= 0) begin
                        expGnt[pick] = 1'b1;
                        expReq   = 1'b1;
                        expAddr  = host_addr_i[pick*AW +: AW];
                        expWe    = host_we_i[pick];
                        expBe    = host_be_i[pick*4 +: 4];
                        expWdata = host_wdata_i[pick*DW +: DW];
                    end
                end else if (bus_rvalid_i) begin
                    expRvalid[mOwner] = 1'b1;
                    expErr[mOwner]    = bus_err_i;
                    expRdata          = bus_rdata_i;
                    done = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                end else if (mWait == TO - 1) begin
                    expRvalid[mOwner] = 1'b1;
                    expErr[mOwner]    = 1'b1;
                    done = 1'b1;
`endif
                end
            end
            checkOutput("model_gnt", 64'(host_gnt_o), 64'(expGnt));
            checkOutput("model_bus_req", 64'(bus_req_o), 64'(expReq));
            checkOutput("model_bus_addr", 64'(bus_addr_o), 64'(expAddr));
            checkOutput("model_bus_we", 64'(bus_we_o), 64'(expWe));
            checkOutput("model_bus_be", 64'(bus_be_o), 64'(expBe));
            checkOutput("model_bus_wdata", 64'(bus_wdata_o), 64'(expWdata));
            checkOutput("model_rvalid", 64'(host_rvalid_o), 64'(expRvalid));
            checkOutput("model_rdata", 64'(host_rdata_o), 64'(expRdata));
            checkOutput("model_err", 64'(host_err_o), 64'(expErr));
            checkOutput("model_busy", 64'(busy_o), 64'(expBusy));
            if (rst_ni) begin
                if (pick >= 0) begin
                    mOutstanding = 1'b1;
                    mOwner = pick;
                    mLast  = pick;
                    mWait  = 0;
                end else if (done) begin
                    mOutstanding = 1'b0;
                    mWait = 0;
                end else if (mOutstanding) begin
                    mWait++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N-1:0] seenGnt;
        logic         seenReq;
        bit           waiting;
        int           lat;

        rst_ni = 1'b0;
        host_req_i = '0; host_addr_i = '0; host_we_i = '0; host_be_i = '0; host_wdata_i = '0;
        bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;

        @(negedge clk_i);
        checkOutput("reset_gnt", 64'(host_gnt_o), 64'h0);
        checkOutput("reset_busy", 64'(busy_o), 64'h0);
        checkOutput("reset_bus_req", 64'(bus_req_o), 64'h0);

        // Single host read, response two cycles after the grant
        doReset();
        applyStimulus(0, 1'b1, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("single_gnt", 64'(host_gnt_o), 64'h1);
        checkOutput("single_addr", 64'(bus_addr_o), 64'h0010_0004);
        checkOutput("single_busy_idle", 64'(busy_o), 64'h0);
        stepCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk_i);
        checkOutput("single_busy_w1", 64'(busy_o), 64'h1);
        checkOutput("single_rvalid_w1", 64'(host_rvalid_o), 64'h0);
        stepCycle();
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        checkOutput("single_rvalid", 64'(host_rvalid_o), 64'h1);
        checkOutput("single_rdata", 64'(host_rdata_o), 64'hDEAD_BEEF);
        checkOutput("single_busy_w2", 64'(busy_o), 64'h1);
        stepCycle();
        bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        @(negedge clk_i);
        checkOutput("single_busy_done", 64'(busy_o), 64'h0);

        // Contention with one-cycle device latency: grants alternate 0,1,0,1
        doReset();
        applyStimulus(0, 1'b1, 32'h1000, 1'b0, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 32'h2000, 1'b0, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checkOutput("contend_gnt", 64'(host_gnt_o), (k % 2 == 0) ? 64'h1 : 64'h2);
            stepCycle();
            bus_rvalid_i = 1'b1; bus_rdata_i = 32'(k);
            @(negedge clk_i);
            checkOutput("contend_rvalid", 64'(host_rvalid_o), (k % 2 == 0) ? 64'h1 : 64'h2);
            stepCycle();
            bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        end

        // Host1 request stalls behind host0, then host1 write receives an error
        doReset();
        applyStimulus(0, 1'b1, 32'h0020_0000, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("hold_gnt0", 64'(host_gnt_o), 64'h1);
        stepCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, 32'h0030_0000, 1'b1, 4'hF, 32'h1234_5678);
        @(negedge clk_i);
        checkOutput("hold_stall", 64'(host_gnt_o), 64'h0);
        stepCycle();
        bus_rvalid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("hold_stall_rvalid", 64'(host_gnt_o), 64'h0);
        checkOutput("hold_rvalid0", 64'(host_rvalid_o), 64'h1);
        stepCycle();
        bus_rvalid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("hold_gnt1", 64'(host_gnt_o), 64'h2);
        checkOutput("err_we", 64'(bus_we_o), 64'h1);
        checkOutput("err_addr", 64'(bus_addr_o), 64'h0030_0000);
        stepCycle();
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_rvalid_i = 1'b1; bus_err_i = 1'b1;
        @(negedge clk_i);
        checkOutput("err_err", 64'(host_err_o), 64'h2);
        checkOutput("err_rvalid", 64'(host_rvalid_o), 64'h2);
        stepCycle();
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0;

        // Reset during WAIT_RESP; a late response must be dropped
        doReset();
        applyStimulus(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("rst_mid_gnt", 64'(host_gnt_o), 64'h1);
        stepCycle();
        rst_ni = 1'b0;
        applyStimulus(1, 1'b1, 32'h80, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("rst_mid_gnt_low", 64'(host_gnt_o), 64'h0);
        checkOutput("rst_mid_busy", 64'(busy_o), 64'h0);
        checkOutput("rst_mid_bus_req", 64'(bus_req_o), 64'h0);
        stepCycle();
        rst_ni = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0BAD;
        @(negedge clk_i);
        checkOutput("rst_late_rvalid", 64'(host_rvalid_o), 64'h0);
        checkOutput("rst_late_rdata", 64'(host_rdata_o), 64'h0);
        checkOutput("rst_first_gnt", 64'(host_gnt_o), 64'h1);
        stepCycle();
        bus_rvalid_i = 1'b0; bus_rdata_i = '0;

`ifdef BUS_ARB_TIMEOUT_EN
        doReset();
        applyStimulus(0, 1'b1, 32'h50, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        checkOutput("to_gnt", 64'(host_gnt_o), 64'h1);
        for (int w = 1; w <= TO; w++) begin
            stepCycle();
            applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            @(negedge clk_i);
            checkOutput("to_rvalid", 64'(host_rvalid_o), (w == TO) ? 64'h1 : 64'h0);
            checkOutput("to_err", 64'(host_err_o), (w == TO) ? 64'h1 : 64'h0);
            checkOutput("to_rdata", 64'(host_rdata_o), 64'h0);
        end
        stepCycle();
        @(negedge clk_i);
        checkOutput("to_idle", 64'(busy_o), 64'h0);
`endif

        // Randomized traffic, checked by the model process every cycle
        doReset();
        waiting = 1'b0;
        lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            seenGnt = host_gnt_o;
            seenReq = bus_req_o;
            stepCycle();
            for (int h = 0; h < N; h++) begin
                if (!(host_req_i[h] && !seenGnt[h] && $urandom_range(0, 15) != 0)) begin
                    applyStimulus(h, $urandom_range(0, 2) != 0, $urandom, 1'($urandom),
                                  4'($urandom), $urandom);
                end
            end
            bus_rvalid_i = 1'b0;
            bus_err_i    = 1'b0;
            bus_rdata_i  = '0;
            if (seenReq) begin
                waiting = 1'b1;
                lat = $urandom_range(0, 3);
            end
            if (waiting) begin
                if (lat == 0) begin
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = $urandom;
                    bus_err_i    = ($urandom_range(0, 3) == 0);
                    waiting = 1'b0;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = $urandom;
                bus_err_i    = 1'($urandom);
            end
        end

        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", chkCount, errCount);
        $finish;
    end

endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Arbitrates the single downstream bus port between NrHosts requesters: core data port (host 0) and debug/JTAG host (host 1).
- Round-robin grant; one outstanding transaction at a time.
- Routes the response (rvalid/rdata/err) back to the granted host only.
- Sits between the hosts and the bus address decoder in the simple SoC.

Parameters:
- NrHosts, 2, number of requesting hosts (2..8)
- DataWidth, 32, data bus width
- AddressWidth, 32, address bus width
- TimeoutCycles, 64, response wait limit (only with BUS_ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- host_req_i  in  NrHosts  per-host request, held until gnt
- host_gnt_o  out  NrHosts  per-host grant, one-hot or zero
- host_addr_i  in  NrHosts*AddressWidth  packed addresses, host h at [h*AW +: AW]
- host_we_i  in  NrHosts  write enables
- host_be_i  in  NrHosts*4  byte enables
- host_wdata_i  in  NrHosts*DataWidth  write data
- host_rvalid_o  out  NrHosts  response valid, one-hot or zero
- host_rdata_o  out  DataWidth  read data, shared; valid only with rvalid
- host_err_o  out  NrHosts  error response, one-hot or zero
- bus_req_o  out  1  downstream request
- bus_addr_o  out  AddressWidth  downstream address
- bus_we_o  out  1  downstream write enable
- bus_be_o  out  4  downstream byte enables
- bus_wdata_o  out  DataWidth  downstream write data
- bus_rvalid_i  in  1  downstream response valid (reads and writes)
- bus_rdata_i  in  DataWidth  downstream read data
- bus_err_i  in  1  downstream error, qualified by bus_rvalid_i
- busy_o  out  1  transaction outstanding

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - last_grant = NrHosts-1, so host 0 wins first
  - owner = 0
  - timeout counter = 0
- States: IDLE, WAIT_RESP.
- IDLE:
  - Combinational pick: first requesting host searching from (last_grant+1) mod NrHosts upward, wrapping.
  - If any request: host_gnt_o[w]=1 that same cycle.
  - bus_req_o=1; bus_addr/we/be/wdata = host w's fields, combinational pass-through.
  - Next edge: owner<=w, last_grant<=w, state<=WAIT_RESP.
  - No request: bus_req_o=0, bus fields 0.
- WAIT_RESP:
  - host_gnt_o=0 and bus_req_o=0; new requests stall.
  - On bus_rvalid_i: host_rvalid_o[owner]=1 and host_rdata_o=bus_rdata_i in the same cycle (combinational); host_err_o[owner]=bus_err_i. Next state IDLE.
  - Earliest regrant is the following cycle. Throughput: 1 transaction per 2 cycles minimum.
- Responses:
  - bus_rvalid_i in IDLE is spurious: ignored, never forwarded.
  - host_rdata_o = 0 whenever no rvalid is driven.
- Fairness: a host requesting continuously is granted at most once before every other requesting host is served.
- Simultaneous events: a new request arriving in the same cycle as rvalid is not granted until IDLE.
- Requests dropped without a grant have no effect (no latching).
- Reset mid-transaction: returns to IDLE and the transaction is abandoned. Any late bus_rvalid_i is then ignored.
- busy_o = (state == WAIT_RESP).

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - In WAIT_RESP a counter increments each cycle without rvalid.
  - When it reaches TimeoutCycles-1 with no rvalid: host_rvalid_o[owner]=1, host_err_o[owner]=1, host_rdata_o=0; state<=IDLE.
  - The counter clears on IDLE entry.
  - A later stray bus_rvalid_i is ignored.
- Undefined: no counter; WAIT_RESP waits indefinitely.

Decomposition:
- Shared package: state enum (IDLE, WAIT_RESP), host index constants HOST_CORE=0, HOST_DBG=1, default TimeoutCycles.
- One sub-module: rr_arbiter. Combinational round-robin picker with inputs req vector and last_grant, outputs one-hot grant and index.

Test Plan:
- Single host: host0 read addr 0x100004; device rvalid 2 cycles later with rdata 0xDEADBEEF -> gnt0 for 1 cycle, bus_addr 0x100004, host_rvalid_o=01, rdata 0xDEADBEEF, busy_o high for 2 cycles.
- Contention: both hosts request continuously, 1-cycle device latency -> grant sequence 0,1,0,1. No host granted twice in a row.
- Hold during busy: host1 raises req while host0 is in WAIT_RESP -> host1 gnt only in the cycle after host0 rvalid.
- Error: device returns rvalid with err=1 for host1 write 0x300000 -> host_err_o=10, host_rvalid_o=10.
- Reset mid-transaction: rst_ni low during WAIT_RESP -> all outputs 0 immediately. A late rvalid after release is not forwarded, and host0 is granted first.
- Timeout (BUS_ARB_TIMEOUT_EN, TimeoutCycles=8): no device response -> err+rvalid to owner on the 8th WAIT_RESP cycle, rdata 0, back to IDLE.
